load_store_unit: RTL and testbench

Sequencing initiator on the CPU side of the byte-addressed, big-endian, word-wide data memory. It accepts one load or store at a time from the MEM stage over a valid/ready request channel. It turns each request into one or two single-cycle MemRead/MemWrite transactions and returns aligned, sign- or zero-extended load data over a valid/ready response channel. Sub-word stores are done as read-modify-write, because the memory writes whole words only.

---
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer for a big-endian, word-wide data memory with read-modify-write sub-word stores.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module load_store_unit #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_load_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_r;
  logic        write_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [1:0]  offset_r;
  logic [31:0] wdata_r;

  logic        req_error_s;
  logic [1:0]  req_offset_s;
  logic [31:0] aligned_address_s;
  logic        unused_addr_s;

  // Offset 0 is the most significant byte lane.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] offset, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (offset)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = offset[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] offset, input logic [31:0] data);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (offset)
          2'd0:    r[31:24] = data[7:0];
          2'd1:    r[23:16] = data[7:0];
          2'd2:    r[15:8]  = data[7:0];
          default: r[7:0]   = data[7:0];
        endcase
      end
      2'b01: begin
        if (offset[1]) r[15:0] = data[15:0];
        else           r[31:16] = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  assign aligned_address_s = {{(32-ADDR_WIDTH){1'b0}}, req_address[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr_s     = ^req_address[31:ADDR_WIDTH];

  // Classify the incoming request: lane offset and error condition.
  always_comb begin
    req_offset_s = 2'b00;
    req_error_s  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    req_offset_s = req_address[1:0];
    req_error_s  = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_address[0]) ||
                   ((req_size == 2'b10) && (req_address[1:0] != 2'b00));
`else
    case (req_size)
      2'b00:   req_offset_s = req_address[1:0];
      2'b01:   req_offset_s = {req_address[1], 1'b0};
      default: req_offset_s = 2'b00;
    endcase
    req_error_s = (req_size == 2'b11);
`endif
  end

  // Request sequencer with registered handshake and memory strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_load_data <= 32'd0;
      resp_error     <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
      write_r        <= 1'b0;
      size_r         <= 2'b00;
      unsigned_r     <= 1'b0;
      offset_r       <= 2'b00;
      wdata_r        <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r     <= req_write;
            size_r      <= req_size;
            unsigned_r  <= req_unsigned;
            offset_r    <= req_offset_s;
            wdata_r     <= req_write_data;
            req_ready   <= 1'b0;
            mem_address <= aligned_address_s;
            if (req_error_s) begin
              resp_valid     <= 1'b1;
              resp_error     <= 1'b1;
              resp_load_data <= 32'd0;
              state_r        <= RESP;
            end else if (!req_write || (req_size != 2'b10)) begin
              mem_read <= 1'b1;
              state_r  <= READ;
            end else begin
              mem_write      <= 1'b1;
              mem_write_data <= req_write_data;
              state_r        <= WRITE;
            end
          end
        end
        READ: begin
          mem_read <= 1'b0;
          if (write_r) begin
            mem_write      <= 1'b1;
            mem_write_data <= store_merge(mem_read_data, size_r, offset_r, wdata_r);
            state_r        <= WRITE;
          end else begin
            resp_valid     <= 1'b1;
            resp_load_data <= load_extend(mem_read_data, size_r, offset_r, unsigned_r);
            state_r        <= RESP;
          end
        end
        WRITE: begin
          mem_write      <= 1'b0;
          resp_valid     <= 1'b1;
          resp_load_data <= 32'd0;
          state_r        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_load_data <= 32'd0;
            req_ready      <= 1'b1;
            state_r        <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_write_data = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_load_data;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  logic [31:0] last_rd_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;

  logic [31:0] mem [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_idx = 9'd0;
  logic [31:0] pl_data = 32'd0;

  load_store_unit #(.ADDR_WIDTH(11)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_address(req_address), .req_write_data(req_write_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_load_data(resp_load_data),
    .resp_error(resp_error), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[10:2]];

  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write) mem[mem_address[10:2]] <= mem_write_data;
  end

  always @(negedge clock) begin
    if (mem_read) begin
      rd_cnt <= rd_cnt + 1;
      last_rd_addr <= mem_address;
    end
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      last_wr_data <= mem_write_data;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_idx = a[10:2]; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Drives one request with resp_ready high and collects the response; no comparisons here.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] d,
                         output logic e, output int rds, output int wrs);
    int rd0, wr0;
    @(negedge clock);
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_write = w; req_size = sz; req_unsigned = u; req_address = a; req_write_data = wd;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    d = resp_load_data; e = resp_error;
    @(negedge clock);
    rds = rd_cnt - rd0; wrs = wr_cnt - wr0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({req_ready, resp_valid, resp_error, mem_read, mem_write} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 10000", {req_ready, resp_valid, resp_error, mem_read, mem_write});
    end
    checks++;
    if ({resp_load_data, mem_address, mem_write_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h expected zeros", resp_load_data, mem_address, mem_write_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_word;
    exp_t x; int lat, rds, wrs; logic [31:0] d; logic e;
    poke(32'h10, 32'h11223344);
    sb.push_back('{32'h11223344, 1'b0, 2});
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, lat, d, e, rds, wrs);
    x = sb.pop_front();
    checks++;
    if (d !== x.data || e !== x.err) begin
      errors++; $display("FAIL load_word data got %h/%b expected %h/%b", d, e, x.data, x.err);
    end
    checks++;
    if (lat !== x.lat) begin errors++; $display("FAIL load_word latency got %0d expected %0d", lat, x.lat); end
    checks++;
    if (rds !== 1 || wrs !== 0 || last_rd_addr !== 32'h10) begin
      errors++; $display("FAIL load_word strobes got rd=%0d wr=%0d addr=%h expected 1 0 00000010", rds, wrs, last_rd_addr);
    end
    // Address bits above ADDR_WIDTH wrap away.
    sb.push_back('{32'h11223344, 1'b0, 2});
    run_req(1'b0, 2'b10, 1'b0, 32'hFFFF_F810, 32'd0, lat, d, e, rds, wrs);
    x = sb.pop_front();
    checks++;
    if (d !== x.data || last_rd_addr !== 32'h10) begin
      errors++; $display("FAIL load_wrap got %h at %h expected %h at 00000010", d, last_rd_addr, x.data);
    end
  endtask

  task automatic test_load_ext;
    logic [1:0]  sz [6]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        un [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [6]  = '{32'h21, 32'h21, 32'h22, 32'h20, 32'h22, 32'h23};
    logic [31:0] ex [6]  = '{32'hFFFFFFFF, 32'h000000FF, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h00000001};
    exp_t x; int lat, rds, wrs; logic [31:0] d; logic e;
    poke(32'h20, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{ex[i], 1'b0, 2});
      run_req(1'b0, sz[i], un[i], ad[i], 32'd0, lat, d, e, rds, wrs);
      x = sb.pop_front();
      checks++;
      if (d !== x.data || e !== x.err || lat !== x.lat || rds !== 1 || wrs !== 0) begin
        errors++;
        $display("FAIL load_ext[%0d] got %h/%b lat %0d rd %0d wr %0d expected %h/%b lat %0d rd 1 wr 0",
                 i, d, e, lat, rds, wrs, x.data, x.err, x.lat);
      end
    end
  endtask

  task automatic test_stores;
    logic [1:0]  sz [3]  = '{2'b00, 2'b01, 2'b10};
    logic [31:0] ad [3]  = '{32'h12, 32'h42, 32'h44};
    logic [31:0] wd [3]  = '{32'h000000AB, 32'h12349876, 32'hCAFEF00D};
    logic [31:0] mw [3]  = '{32'h1122AB44, 32'h01029876, 32'hCAFEF00D};
    int          er [3]  = '{1, 1, 0};
    logic [31:0] wa [3]  = '{32'h10, 32'h40, 32'h44};
    exp_t x; int lat, rds, wrs; logic [31:0] d; logic e;
    poke(32'h10, 32'h11223344);
    poke(32'h40, 32'h01020304);
    poke(32'h44, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'd0, 1'b0, (er[i] == 1) ? 3 : 2});
      run_req(1'b1, sz[i], 1'b0, ad[i], wd[i], lat, d, e, rds, wrs);
      x = sb.pop_front();
      checks++;
      if (d !== x.data || e !== x.err || lat !== x.lat || rds !== er[i] || wrs !== 1 || last_wr_data !== mw[i]) begin
        errors++;
        $display("FAIL store[%0d] got %h/%b lat %0d rd %0d wr %0d wdata %h expected %h/%b lat %0d rd %0d wr 1 wdata %h",
                 i, d, e, lat, rds, wrs, last_wr_data, x.data, x.err, x.lat, er[i], mw[i]);
      end
      sb.push_back('{mw[i], 1'b0, 2});
      run_req(1'b0, 2'b10, 1'b0, wa[i], 32'd0, lat, d, e, rds, wrs);
      x = sb.pop_front();
      checks++;
      if (d !== x.data) begin errors++; $display("FAIL store_reload[%0d] got %h expected %h", i, d, x.data); end
    end
  endtask

  task automatic test_errors;
    exp_t x; int lat, rds, wrs; logic [31:0] d; logic e;
    sb.push_back('{32'd0, 1'b1, 1});
    run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, lat, d, e, rds, wrs);
    x = sb.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || lat !== x.lat || rds !== 0 || wrs !== 0) begin
      errors++; $display("FAIL size11 got %h/%b lat %0d rd %0d wr %0d expected %h/%b lat %0d no strobes",
                         d, e, lat, rds, wrs, x.data, x.err, x.lat);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    sb.push_back('{32'd0, 1'b1, 1});
    sb.push_back('{32'd0, 1'b1, 1});
`else
    sb.push_back('{32'h80FF7F01, 1'b0, 2});
    sb.push_back('{32'hFFFF80FF, 1'b0, 2});
`endif
    run_req(1'b0, 2'b10, 1'b0, 32'h22, 32'd0, lat, d, e, rds, wrs);
    x = sb.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || lat !== x.lat || rds !== (x.err ? 0 : 1) || wrs !== 0) begin
      errors++; $display("FAIL misalign_word got %h/%b lat %0d rd %0d expected %h/%b lat %0d", d, e, lat, rds, x.data, x.err, x.lat);
    end
    run_req(1'b0, 2'b01, 1'b0, 32'h21, 32'd0, lat, d, e, rds, wrs);
    x = sb.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || lat !== x.lat) begin
      errors++; $display("FAIL misalign_half got %h/%b lat %0d expected %h/%b lat %0d", d, e, lat, x.data, x.err, x.lat);
    end
  endtask

  task automatic test_backpressure;
    exp_t x; int lat; logic ok;
    poke(32'h10, 32'h0BADF00D);
    resp_ready = 1'b0;
    @(negedge clock);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_address = 32'h10; req_valid = 1'b1;
    sb.push_back('{32'h0BADF00D, 1'b0, 2});
    @(posedge clock);
    @(negedge clock);
    req_address = 32'h20;
    sb.push_back('{32'h80FF7F01, 1'b0, 2});
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
    x = sb.pop_front();
    checks++;
    if (lat !== x.lat) begin errors++; $display("FAIL bp_latency got %0d expected %0d", lat, x.lat); end
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b1 || resp_load_data !== x.data || req_ready !== 1'b0) ok = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (ok !== 1'b1 || resp_load_data !== x.data) begin
      errors++; $display("FAIL bp_hold got %h valid %b ready %b expected %h held", resp_load_data, resp_valid, req_ready, x.data);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready %b valid %b expected 1 0", req_ready, resp_valid);
    end
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
    x = sb.pop_front();
    checks++;
    if (resp_load_data !== x.data || lat !== x.lat) begin
      errors++; $display("FAIL bp_second got %h lat %0d expected %h lat %0d", resp_load_data, lat, x.data, x.lat);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_write;
    exp_t x; int lat, rds, wrs; logic [31:0] d; logic e; logic seen;
    poke(32'h30, 32'h55667788);
    @(negedge clock);
    req_write = 1'b1; req_size = 2'b10; req_address = 32'h30; req_write_data = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_write_cycle got mem_write %b expected 1", mem_write); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async got wr %b valid %b ready %b expected 0 0 1", mem_write, resp_valid, req_ready);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_resp got resp_seen %b ready %b expected 0 1", seen, req_ready);
    end
    sb.push_back('{32'h55667788, 1'b0, 2});
    run_req(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, lat, d, e, rds, wrs);
    x = sb.pop_front();
    checks++;
    if (d !== x.data) begin errors++; $display("FAIL rst_mem_untouched got %h expected %h", d, x.data); end
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap got %0d expected 0", both_cnt); end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_stores();
    test_errors();
    test_backpressure();
    test_reset_mid_write();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
